timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 76 +++++++
 tb/tb_timer_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Two-digit BCD preset down-counter (phase timer). Reloads whenever RS changes.
// Define TIMER_COUNTER_AUTO_RELOAD_EN for periodic reload with a one-cycle QCC pulse.
module timer_counter #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       CP,
  input  logic       CR,
  input  logic [7:0] RS,
  output logic [7:0] Q,
  output logic       QCC
);

  localparam logic [15:0] PsMax = 16'(PRESCALE - 1);

  logic [7:0]  rs_q;
  logic        load_pend;
  logic [15:0] prescaler;

  logic [7:0]  rs_san;
  logic [7:0]  q_dec;
  logic [7:0]  q_step;
  logic        qcc_step;
  logic        load;

  function automatic logic [7:0] sanitise(input logic [7:0] v);
    logic [7:0] r;
    r[7:4] = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    r[3:0] = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return r;
  endfunction

  always_comb begin
    rs_san = sanitise(RS);
    load   = load_pend || (RS != rs_q);
    // BCD decrement; only used while Q != 00, so tens never underflows
    if (Q[3:0] == 4'd0) begin
      q_dec = {Q[7:4] - 4'd1, 4'd9};
    end else begin
      q_dec = {Q[7:4], Q[3:0] - 4'd1};
    end
    q_step   = q_dec;
    qcc_step = (q_dec == 8'h00);
`ifdef TIMER_COUNTER_AUTO_RELOAD_EN
    if (q_dec == 8'h00) begin
      q_step = sanitise(rs_q);
    end
`endif
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      Q         <= 8'h00;
      QCC       <= 1'b0;
      rs_q      <= 8'h00;
      load_pend <= 1'b1;
      prescaler <= 16'd0;
    end else if (load) begin
      Q         <= rs_san;
      QCC       <= (rs_san == 8'h00);
      rs_q      <= RS;
      load_pend <= 1'b0;
      prescaler <= 16'd0;
    end else if (Q != 8'h00) begin
      // QCC is low whenever Q is non-zero, except for the reload pulse
      if (prescaler == PsMax) begin
        prescaler <= 16'd0;
        Q         <= q_step;
        QCC       <= qcc_step;
      end else begin
        prescaler <= prescaler + 16'd1;
        QCC       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: PRESCALE=1 and PRESCALE=4 instances share stimulus and are
// checked every cycle against a decimal-count model, plus hand-computed literal checks.
module tb_timer_counter;

`ifdef TIMER_COUNTER_AUTO_RELOAD_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic [7:0] RS = 8'h15;
  logic [7:0] q1, q4;
  logic       qcc1, qcc4;

  int n_cmp  = 0;
  int n_fail = 0;

  timer_counter #(.PRESCALE(1)) dut1 (.CP(CP), .CR(CR), .RS(RS), .Q(q1), .QCC(qcc1));
  timer_counter #(.PRESCALE(4)) dut4 (.CP(CP), .CR(CR), .RS(RS), .Q(q4), .QCC(qcc4));

  always #5 CP = ~CP;

  // Model state: count kept as a plain decimal integer.
  int         ps[2]   = '{1, 4};
  int         cnt[2]  = '{0, 0};
  int         pre[2]  = '{0, 0};
  bit         mqcc[2] = '{0, 0};
  bit         pend[2] = '{1, 1};
  logic [7:0] rsp[2]  = '{8'h00, 8'h00};

  function automatic int dec_of(input logic [7:0] v);
    int t, u;
    t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    u = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    return t * 10 + u;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  always @(posedge CP or negedge CR) begin
    for (int i = 0; i < 2; i++) begin
      int c, p;
      bit f, pd;
      logic [7:0] r;
      c = cnt[i]; p = pre[i]; f = mqcc[i]; pd = pend[i]; r = rsp[i];
      if (!CR) begin
        c = 0; p = 0; f = 0; pd = 1; r = 8'h00;
      end else if (pd || RS != r) begin
        c = dec_of(RS); r = RS; pd = 0; p = 0; f = (c == 0);
      end else if (c != 0) begin
        if (p == ps[i] - 1) begin
          p = 0;
          c = c - 1;
          f = (c == 0);
          if (c == 0 && Auto) c = dec_of(r);
        end else begin
          p = p + 1;
          f = 0;
        end
      end
      cnt[i] <= c; pre[i] <= p; mqcc[i] <= f; pend[i] <= pd; rsp[i] <= r;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge CP) begin
    chk("model_q_p1", q1, to_bcd(cnt[0]));
    chk("model_qcc_p1", {7'd0, qcc1}, {7'd0, mqcc[0]});
    chk("model_q_p4", q4, to_bcd(cnt[1]));
    chk("model_qcc_p4", {7'd0, qcc4}, {7'd0, mqcc[1]});
  end

  task automatic edges(input int n);
    repeat (n) @(negedge CP);
    #1;
  endtask

  initial begin
    #1 CR = 1'b0;
    edges(2);
    chk("rst_q", q1, 8'h00);
    chk("rst_qcc", {7'd0, qcc1}, 8'h00);
    CR = 1'b1;
    edges(1); chk("load15", q1, 8'h15); chk("load15_qcc", {7'd0, qcc1}, 8'h00);
    edges(1); chk("step14", q1, 8'h14);
    edges(4); chk("step10", q1, 8'h10);
    edges(1); chk("borrow09", q1, 8'h09);
    edges(9); chk("expire", q1, Auto ? 8'h15 : 8'h00);
    chk("expire_qcc", {7'd0, qcc1}, 8'h01);
    edges(3); chk("hold", q1, Auto ? 8'h12 : 8'h00);
    chk("hold_qcc", {7'd0, qcc1}, Auto ? 8'h00 : 8'h01);

    RS = 8'h31;
    edges(1); chk("load31", q1, 8'h31); chk("load31_qcc", {7'd0, qcc1}, 8'h00);
    edges(1); chk("step30", q1, 8'h30);
    edges(1); chk("borrow29", q1, 8'h29);
    edges(1); chk("step28", q1, 8'h28);
    edges(27); chk("step01", q1, 8'h01); chk("step01_qcc", {7'd0, qcc1}, 8'h00);
    edges(1); chk("expire31", q1, Auto ? 8'h31 : 8'h00);
    chk("expire31_qcc", {7'd0, qcc1}, 8'h01);

    RS = 8'hAF;
    edges(1); chk("clampAF", q1, 8'h99);
    edges(1); chk("step98", q1, 8'h98);
    RS = 8'h3C;
    edges(1); chk("clamp3C", q1, 8'h39);
    RS = 8'h00;
    edges(1); chk("load00", q1, 8'h00); chk("load00_qcc", {7'd0, qcc1}, 8'h01);

    RS = 8'h02;
    edges(1); chk("p4_load", q4, 8'h02);
    edges(3); chk("p4_hold02", q4, 8'h02);
    edges(1); chk("p4_step01", q4, 8'h01); chk("p4_step01_qcc", {7'd0, qcc4}, 8'h00);
    edges(3); chk("p4_hold01", q4, 8'h01);
    edges(1); chk("p4_expire", q4, Auto ? 8'h02 : 8'h00);
    chk("p4_expire_qcc", {7'd0, qcc4}, 8'h01);

    RS = 8'h20;
    edges(1); chk("load20", q1, 8'h20);
    edges(2); chk("step18", q1, 8'h18);
    RS = 8'h21;
    edges(1); chk("reload21", q1, 8'h21);
    RS = 8'h20;
    edges(1); chk("toggle_back20", q1, 8'h20);

    RS = 8'h09;
    edges(1); chk("load09", q1, 8'h09);
    edges(2); chk("step07", q1, 8'h07);
    CR = 1'b0;
    #1 chk("async_rst_q", q1, 8'h00); chk("async_rst_qcc", {7'd0, qcc1}, 8'h00);
    #1 CR = 1'b1;
    edges(1); chk("reload_after_rst", q1, 8'h09);

    RS = 8'h03;
    edges(1); chk("ar_03", q1, 8'h03);
    edges(1); chk("ar_02", q1, 8'h02);
    edges(1); chk("ar_01", q1, 8'h01);
    edges(1); chk("ar_wrap", q1, Auto ? 8'h03 : 8'h00);
    chk("ar_wrap_qcc", {7'd0, qcc1}, 8'h01);
    edges(1); chk("ar_next", q1, Auto ? 8'h02 : 8'h00);
    chk("ar_next_qcc", {7'd0, qcc1}, Auto ? 8'h00 : 8'h01);

    edges(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
